irq_source_ctrl: RTL
====================

Name: irq_source_ctrl

Overview:
- Produces the 2-bit interrupt request code that the instruction control decoder consumes. Code 01 means timer, 10 means UART, 11 means external.
- Contains the memory-mapped system timer (TH/TL/TCON), per-source pending latches, a mask register and a fixed-priority encoder.
- Clears the granted source's pending bit in the same cycle the single-cycle datapath takes the interrupt.
- Sits on the peripheral bus beside data memory. Its irq output feeds the control decoder's IRQ input.

Parameters:
- TIMER_W, 32, width of TH/TL.
- PRIO_TIMER_FIRST, 1, when 1 the fixed priority is timer > uart > ext; when 0 it is ext > uart > timer.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- monin  in  1  kernel-mode flag (PC[31]); 1 means interrupts are ignored by the core
- uart_irq  in  1  level request from the UART
- ext_irq  in  1  request from an external pin, already synchronised
- sel  in  1  peripheral chip select
- addr  in  3  word offset (bus addr[4:2])
- we  in  1  write strobe
- wdata  in  32  write data
- rdata  out  32  read data, combinational from registers
- irq  out  2  request code: 00 none, 01 timer, 10 uart, 11 ext

Behaviour:
- Register map (offset):
  - 0 TH, R/W.
  - 1 TL, R/W.
  - 2 TCON, R/W, bits [2:0] only: bit0 run, bit1 irq_en, bit2 status (write 0 clears it).
  - 3 PEND, read [2:0] = {ext,uart,timer}; write-1-to-clear.
  - 4 MASK, R/W, bits [2:0]; 1 means enabled.
  - Unmapped offsets read 0; writes to them are ignored; unused bits read 0.
- Reset (reset==0 at a rising edge):
  - TH=0, TL=0, TCON=0, PEND=0, MASK=3'b111.
  - irq=00, rdata=0.
- Timer counting:
  - When TCON.run=1, TL increments each cycle.
  - When TL==all-ones with run=1: TL<=TH on the next edge (no intermediate 0). If irq_en=1, TCON.status<=1 and PEND.timer<=1 on that edge.
  - A bus write to TL in the same cycle overrides both increment and reload.
  - Writing TCON with run=0 freezes TL at its current value.
- Pending latches:
  - uart: PEND.uart set on any cycle uart_irq=1.
  - ext: level; set on any cycle ext_irq=1 (see optional feature).
  - A source's pending bit is set even if its MASK bit is 0. Only irq generation is masked.
- Encoding:
  - eff = PEND & MASK.
  - irq is a fixed-priority encode of eff per PRIO_TIMER_FIRST; 00 if eff==0.
  - irq is combinational from registers only; it does not depend on monin. The decoder applies the monin gate.
- Take:
  - take = (monin==0) && (irq!=00).
  - On take, the pending bit of the source encoded on irq clears at that edge; TCON.status is not touched.
- Simultaneous events:
  - Set beats take: a new set event for the same source on the take edge leaves the bit at 1.
  - Set beats a PEND W1C write in the same cycle.
  - take and a W1C clear of different bits both apply.
- monin=1: irq may be non-zero, but nothing is cleared. Requests are held until monin returns to 0.
- Reset mid-count or with pending requests: all state returns to reset values on that edge, and irq=00 the following cycle.
- Latency:
  - Source event at edge N means irq is valid after edge N.
  - Taken at edge N+1 when monin=0; the next-priority source appears after edge N+1.

Optional Feature:
- Macro EXT_EDGE_EN.
- Defined:
  - ext_irq is registered into ext_d.
  - PEND.ext is set only on a rising edge (ext_irq & ~ext_d).
  - ext_d resets to 0.
  - A held-high ext_irq produces exactly one pending event.
- Undefined: level behaviour as above. A held-high ext_irq re-sets PEND.ext every cycle, so it reappears immediately after take.

Test Plan:
- Timer overflow: write TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3 with monin=1.
  - Required: TL reads 0xFFFFFFFF, then 0xFFFFFFF0.
  - Required: TCON reads 7 and irq=01.
  - Then drop monin for one cycle: PEND reads 0 and irq=00.
- Priority: with monin=1 and PRIO_TIMER_FIRST=1, assert uart_irq and ext_irq for 1 cycle.
  - Required: irq=10.
  - With monin=0, after the first take irq=11; after the second take irq=00.
- Mask: MASK=3'b101, pulse uart_irq.
  - Required: irq=00 and PEND reads 3'b010.
  - Write MASK=3'b111: irq=10 the next cycle.
- Set-beats-take: timer irq pending with monin=0, and a new overflow lands on the take edge.
  - Required: PEND.timer stays 1 and irq=01 persists.
- W1C and reset: PEND=3'b111, write PEND=3'b011.
  - Required: PEND reads 3'b100 and irq=11.
  - Assert reset for 1 cycle mid-count (TL=0x1234 running): TL=0, TCON=0, MASK=7, irq=00.
- EXT_EDGE_EN: with the macro defined, hold ext_irq=1 for 10 cycles with monin=0.
  - Required: irq=11 exactly one cycle, then 00.
  - Without the macro: irq=11 on every cycle after the first.

Source files
------------

// File: rtl/irq_source_ctrl.sv
// Interrupt source controller: system timer (TH/TL/TCON), per-source pending latches,
// mask and fixed-priority encoder. Define EXT_EDGE_EN to latch ext_irq on rising edges only.
module irq_source_ctrl #(
  parameter int TIMER_W          = 32,
  parameter bit PRIO_TIMER_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        monin,
  input  logic        uart_irq,
  input  logic        ext_irq,
  input  logic        sel,
  input  logic [2:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [1:0]  irq
);

  localparam logic [2:0] ADDR_TH   = 3'd0;
  localparam logic [2:0] ADDR_TL   = 3'd1;
  localparam logic [2:0] ADDR_TCON = 3'd2;
  localparam logic [2:0] ADDR_PEND = 3'd3;
  localparam logic [2:0] ADDR_MASK = 3'd4;
  localparam int         RD_W      = (TIMER_W < 32) ? TIMER_W : 32;

  logic [TIMER_W-1:0] th_reg, th_next;
  logic [TIMER_W-1:0] tl_reg, tl_next;
  logic [2:0]         tcon_reg, tcon_next;   // {status, irq_en, run}
  logic [2:0]         pend_reg, pend_next;   // {ext, uart, timer}
  logic [2:0]         mask_reg, mask_next;

  logic       wr_en;
  logic       overflow;
  logic       timer_set;
  logic       ext_set;
  logic [2:0] eff;
  logic [2:0] grant;
  logic [2:0] set_vec;
  logic [2:0] w1c_vec;
  logic       take;

  assign wr_en     = sel & we;
  assign overflow  = tcon_reg[0] && (tl_reg == '1);
  assign timer_set = overflow && tcon_reg[1];

`ifdef EXT_EDGE_EN
  logic ext_d_reg;
  assign ext_set = ext_irq & ~ext_d_reg;
`else
  assign ext_set = ext_irq;
`endif

  // Fixed-priority grant; irq code is derived from the one-hot grant.
  always_comb begin
    eff   = pend_reg & mask_reg;
    grant = 3'b000;
    if (PRIO_TIMER_FIRST) begin
      if (eff[0])      grant = 3'b001;
      else if (eff[1]) grant = 3'b010;
      else if (eff[2]) grant = 3'b100;
    end else begin
      if (eff[2])      grant = 3'b100;
      else if (eff[1]) grant = 3'b010;
      else if (eff[0]) grant = 3'b001;
    end
    irq = {grant[2] | grant[1], grant[2] | grant[0]};
  end

  assign take    = ~monin & (|grant);
  assign set_vec = {ext_set, uart_irq, timer_set};
  assign w1c_vec = (wr_en && addr == ADDR_PEND) ? wdata[2:0] : 3'b000;

  // A set event always wins over a take or W1C clear landing on the same edge.
  for (genvar gi = 0; gi < 3; gi++) begin : g_pend
    assign pend_next[gi] = set_vec[gi] |
                           (pend_reg[gi] & ~w1c_vec[gi] & ~(take & grant[gi]));
  end

  always_comb begin
    th_next   = th_reg;
    tl_next   = tl_reg;
    tcon_next = tcon_reg;
    mask_next = mask_reg;

    if (wr_en && addr == ADDR_TL) tl_next = TIMER_W'(wdata);
    else if (overflow)            tl_next = th_reg;
    else if (tcon_reg[0])         tl_next = tl_reg + 1'b1;

    if (wr_en && addr == ADDR_TH)   th_next   = TIMER_W'(wdata);
    if (wr_en && addr == ADDR_TCON) tcon_next = wdata[2:0];
    if (timer_set)                  tcon_next[2] = 1'b1;
    if (wr_en && addr == ADDR_MASK) mask_next = wdata[2:0];
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (addr)
        ADDR_TH:   rdata[RD_W-1:0] = th_reg[RD_W-1:0];
        ADDR_TL:   rdata[RD_W-1:0] = tl_reg[RD_W-1:0];
        ADDR_TCON: rdata[2:0]      = tcon_reg;
        ADDR_PEND: rdata[2:0]      = pend_reg;
        ADDR_MASK: rdata[2:0]      = mask_reg;
        default:   rdata           = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      th_reg   <= '0;
      tl_reg   <= '0;
      tcon_reg <= 3'b000;
      pend_reg <= 3'b000;
      mask_reg <= 3'b111;
`ifdef EXT_EDGE_EN
      ext_d_reg <= 1'b0;
`endif
    end else begin
      th_reg   <= th_next;
      tl_reg   <= tl_next;
      tcon_reg <= tcon_next;
      pend_reg <= pend_next;
      mask_reg <= mask_next;
`ifdef EXT_EDGE_EN
      ext_d_reg <= ext_irq;
`endif
    end
  end

endmodule
